// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared FSM states, curve constants and sizing helpers for the GF(2^M) multipliers.
package gf2m_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int             M_163K1    = 163;
    localparam logic [162:0]   POLY_163K1 = 163'hC9;
    localparam int             M_233K1    = 233;
    localparam logic [232:0]   POLY_233K1 = (233'd1 << 74) | 233'd1;
    localparam int             M_283K1    = 283;
    localparam logic [282:0]   POLY_283K1 = 283'h10A1;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// gf2m_digit_step: one Horner step, o_acc = (i_acc * x^D + i_a * i_digit) mod f, reduced bit by bit.
module gf2m_digit_step
    import gf2m_pkg::*;
#(
    parameter int         M    = M_163K1,
    parameter int         D    = 1,
    parameter logic [M-1:0] POLY = M'(POLY_163K1)
) (
    input  logic [M-1:0] i_acc,
    input  logic [M-1:0] i_a,
    input  logic [D-1:0] i_digit,
    output logic [M-1:0] o_acc
);

    always_comb begin
        o_acc = i_acc;
        for (int i = D - 1; i >= 0; i--)
            o_acc = {o_acc[M-2:0], 1'b0} ^ (o_acc[M-1] ? POLY : '0) ^ (i_digit[i] ? i_a : '0);
    end

endmodule

// File: rtl/gf2m_digit_mul.sv
// gf2m_digit_mul: digit-serial GF(2^M) multiplier, MSB digit first, one digit per cycle.
// Optional one-cycle squaring path enabled by GF2M_MUL_SQR_EN.
module gf2m_digit_mul
    import gf2m_pkg::*;
#(
    parameter int           M    = M_163K1,
    parameter int           D    = 1,
    parameter logic [M-1:0] POLY = M'(POLY_163K1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         start,
`ifdef GF2M_MUL_SQR_EN
    input  logic         sqr,
`endif
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] z
);

    localparam int N  = ceil_div(M, D);
    localparam int NB = N * D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (D < 1 || D > M) begin : g_bad_d
        $error("gf2m_digit_mul: D must satisfy 1 <= D <= M");
    end

    state_t        r_state;
    state_t        w_next;
    logic [M-1:0]  r_acc;
    logic [M-1:0]  r_a;
    logic [M-1:0]  r_z;
    logic [NB-1:0] r_b;
    logic [CW-1:0] r_cnt;
    logic [M-1:0]  w_step;
    logic [M-1:0]  w_sq;
    logic          w_sqr;
    logic          w_accept;
    logic          w_last;

`ifdef GF2M_MUL_SQR_EN
    logic [2*M-1:0] w_il;

    always_comb begin
        w_il = '0;
        for (int i = 0; i < M; i++)
            w_il[2*i] = a[i];
    end

    // a^2 = hi*x^M + lo; a full-width Horner step with multiplicand 1 folds hi in and adds lo.
    gf2m_digit_step #(.M(M), .D(M), .POLY(POLY)) u_sq (
        .i_acc   (w_il[2*M-1:M]),
        .i_a     (M'(1)),
        .i_digit (w_il[M-1:0]),
        .o_acc   (w_sq)
    );

    assign w_sqr = sqr;
`else
    assign w_sqr = 1'b0;
    assign w_sq  = '0;
`endif

    gf2m_digit_step #(.M(M), .D(D), .POLY(POLY)) u_step (
        .i_acc   (r_acc),
        .i_a     (r_a),
        .i_digit (r_b[NB-1 -: D]),
        .o_acc   (w_step)
    );

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_state == RUN) && (r_cnt == '0);

    always_comb begin
        w_next = clr ? IDLE :
                 w_accept ? (w_sqr ? DONE : RUN) :
                 w_last ? DONE :
                 (r_state == RUN) ? RUN : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_z   <= '0;
        end else if (clr) begin
            r_acc <= '0;
            r_z   <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= NB'(b);
            r_acc <= '0;
            r_cnt <= CW'(N - 1);
            if (w_sqr)
                r_z <= w_sq;
        end else if (r_state == RUN) begin
            r_acc <= w_step;
            r_b   <= r_b << D;
            r_cnt <= r_cnt - 1'b1;
            if (w_last)
                r_z <= w_step;
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign z    = r_z;

endmodule

// File: doc/gf2m_digit_mul.md
Name: gf2m_digit_mul

Overview:
- Parametrised digit-serial GF(2^M) multiplier, polynomial basis, reduction polynomial f(x) = x^M + POLY(x).
- Generalises the fixed-field arithmetic inside the sect163k1 point multiplier to any binary field and any digit size D, trading area against latency.
- Uses the same clr/start/done control style as the point-multiplier family.
- Intended as the shared field-multiply engine for point-multiplication datapaths (sect163k1, sect233k1, sect283k1, ...).

Parameters:
- M, 163, field degree; width of a, b and z.
- D, 1, digit size in bits; 1 <= D <= M. Violation raises an elaboration-time $error.
- POLY, 163'hC9, low-order terms of f(x), M bits wide. The default gives x^163+x^7+x^6+x^3+1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear.
- start  input  1  operation request, single-cycle pulse.
- a  input  M  multiplicand, sampled on an accepted start.
- b  input  M  multiplier, sampled on an accepted start.
- sqr  input  1  squaring mode select. Present only with GF2M_MUL_SQR_EN.
- busy  output  1  high while the operation is iterating.
- done  output  1  one-cycle pulse: z is valid.
- z  output  M  result a*b mod f, held until the next accepted start or clr.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; acc, b_reg, a_reg, cnt, z all 0; busy=0; done=0.
- clr=1 at a clock edge has priority over start. It forces IDLE and zeroes acc, z and done. This applies in any state, including mid-RUN; the aborted operation never produces done.
- N = ceil(M/D). b is zero-padded at the MSB end to N*D bits and split into digits b_{N-1}..b_0. Processing is MSB digit first.
- Iteration, one digit per cycle:
  - acc <= ((acc * x^D) mod f) XOR ((a * b_i) mod f).
  - Reduction is combinational, a D-step shift/xor loop, so no constraint on the degree of POLY.
- States:
  - IDLE: start accepted -> capture a and b, acc=0, cnt=N-1, go to RUN.
  - RUN: busy=1. Each edge applies one digit and decrements cnt. On the edge processing cnt==0: z <= new acc, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start sampled in DONE is accepted exactly as in IDLE (back-to-back, no idle gap).
- Latency: start sampled at edge t -> done high in the cycle after edge t+N, and z valid from that same edge.
  - M=163, D=1: N=163.
  - M=163, D=4: N=41.
- start while in RUN is ignored; no queueing.
- a and b change freely after an accepted start, because they are registered.
- z changes only on the final iteration edge, on clr, or on reset.

Optional Feature:
- Macro GF2M_MUL_SQR_EN.
- Defined:
  - sqr port exists.
  - start with sqr=1 computes z = a^2 mod f in one cycle: zero-interleave a, reduce combinationally, go straight to DONE.
  - done is high in the cycle after the start edge; busy stays 0.
  - b is ignored.
- Undefined: no sqr port; squaring uses the normal N-cycle path with b=a.

Decomposition:
- Package gf2m_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - curve constants M_163K1=163 and POLY_163K1=163'hC9, plus M/POLY for sect233k1 and sect283k1;
  - a ceil-division function for N.
- One combinational sub-module, gf2m_digit_step (parameters M, D, POLY): inputs acc, a, digit; output next acc. It isolates the reduction logic and is reused by the squaring path.

Test Plan:
- M=4, D=1, POLY=4'h3: a=4'h2, b=4'h8 -> z=4'h3; done exactly 4 cycles after start; busy high for 4 cycles.
- M=4, D=2, POLY=4'h3: a=4'h8, b=4'h8 -> z=4'hC after 2 cycles. Back-to-back start in the DONE cycle with a=4'h1, b=4'h5 -> z=4'h5 with no gap.
- M=163, D=4 default poly:
  - a=163'h1, b=random -> z=b.
  - a=0 -> z=0.
  - a=1<<162, b=163'h2 -> z=163'hC9.
  - Latency 41 cycles for each.
  - Random a, b checked against the reference-model file.
- M=163, D=1:
  - start, then clr at cycle 10 -> no done pulse, z=0, state IDLE.
  - Next start completes after 163 cycles.
  - Assert rst_n=0 mid-RUN -> all outputs 0 immediately.
- With GF2M_MUL_SQR_EN, M=4, POLY=4'h3: sqr=1, a=4'h8 -> z=4'hC, done in the cycle after start, busy never high. A start during RUN is ignored.
